ifu_fetch_queue: RTL and testbench

IFU_FETCH_QUEUE -- requirements
Module: ifu_fetch_queue

---
 rtl/ifu_fetch_queue.sv | 153 +++++++++++++++
 tb/tb_ifu_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue -- decoupling queue between instruction memory and IF/ID.
//
// Memory responses are buffered in a DEPTH-entry circular buffer. The head
// entry is presented to the IF/ID register. A credit scheme keeps the buffer
// from overflowing: fetches may issue only while buffered entries plus
// in-flight requests are fewer than DEPTH. After a flush, responses that
// were already in flight come back stale. They are counted in drop_cnt and
// discarded.
//
// Optional feature: define IFU_FQ_BYPASS_EN to let a live response reach the
// outputs in the same cycle when the queue is empty. The default build has
// no combinational path from rsp_* to the outputs.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_issue_i              fetch request accepted by memory this cycle
//   req_allow_o              credit available for another fetch
//   rsp_valid_i/inst/addr/pred_branch  memory response (never back-pressured)
//   flush_flag_i             pipeline redirect: empty queue, mark in-flight stale
//   stall_i                  IF/ID holding; head is not consumed
//   inst_o, inst_addr_o, is_pred_branch_o, inst_valid_o  head entry
//   fq_count_o               current occupancy

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 64
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

module ifu_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_issue_i,
  output logic                        req_allow_o,
  input  logic                        rsp_valid_i,
  input  logic [`INST_DATA_WIDTH-1:0] rsp_inst_i,
  input  logic [`INST_ADDR_WIDTH-1:0] rsp_addr_i,
  input  logic                        rsp_pred_branch_i,
  input  logic                        flush_flag_i,
  input  logic                        stall_i,
  output logic [`INST_DATA_WIDTH-1:0] inst_o,
  output logic [`INST_ADDR_WIDTH-1:0] inst_addr_o,
  output logic                        is_pred_branch_o,
  output logic                        inst_valid_o,
  output logic [$clog2(DEPTH):0]      fq_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = `INST_DATA_WIDTH;
  localparam int AW = `INST_ADDR_WIDTH;
  localparam int EW = DW + AW + 1;

  // Entry layout: {inst, addr, pred}. The head is read asynchronously from
  // the registered read pointer. This keeps the response-to-output latency
  // at one cycle.
  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg, outstanding_reg, drop_cnt_reg;
  logic [CW-1:0] outstanding_next;
  logic [CW:0]   credit_sum;

  logic          rsp_live, q_empty, byp_hit, head_valid, enq, deq;
  logic [EW-1:0] head_entry;

  assign outstanding_next = outstanding_reg + CW'(req_issue_i) - CW'(rsp_valid_i);
  assign rsp_live         = rsp_valid_i && (drop_cnt_reg == '0);
  assign q_empty          = (count_reg == '0);

`ifdef IFU_FQ_BYPASS_EN
  assign byp_hit = q_empty && rsp_live && !flush_flag_i && !rst;
`else
  assign byp_hit = 1'b0;
`endif

  // Reset and flush both blank the outputs immediately. They do not wait for
  // the state to clear.
  assign head_valid = (!q_empty || byp_hit) && !flush_flag_i && !rst;

  // A bypassed response that is consumed in the same cycle never touches the
  // buffer. If the response is stalled, it is written to the buffer and
  // becomes the head.
  assign deq = head_valid && !stall_i && !byp_hit;
  assign enq = rsp_live && !flush_flag_i && !rst && !(byp_hit && !stall_i);

  always_comb begin
    head_entry = mem[rd_ptr_reg];
`ifdef IFU_FQ_BYPASS_EN
    if (byp_hit) head_entry = {rsp_inst_i, rsp_addr_i, rsp_pred_branch_i};
`endif
  end

  assign inst_o           = head_valid ? head_entry[EW-1 -: DW] : {`INST_NOP, `INST_NOP};
  assign inst_addr_o      = head_valid ? head_entry[1 +: AW]    : `ZeroWord;
  assign is_pred_branch_o = head_valid ? head_entry[0]          : 1'b0;
  assign inst_valid_o     = head_valid;
  assign fq_count_o       = count_reg;

  // Compare one bit wider so the sum cannot wrap.
  assign credit_sum  = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign req_allow_o = credit_sum < (CW+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr_reg] <= {rsp_inst_i, rsp_addr_i, rsp_pred_branch_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (flush_flag_i) begin
        // Everything still in flight after this cycle is stale. That
        // includes a request issued in this same cycle.
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
        count_reg    <= '0;
        drop_cnt_reg <= outstanding_next;
      end else begin
        if (rsp_valid_i && (drop_cnt_reg != '0)) drop_cnt_reg <= drop_cnt_reg - CW'(1);
        if (enq) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (deq) rd_ptr_reg <= rd_ptr_reg + PW'(1);
        count_reg <= count_reg + CW'(enq) - CW'(deq);
      end
    end
  end

  // Protocol checks: a full queue cannot accept without a dequeue, and
  // memory cannot respond to a request that was never issued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(enq && !deq && (count_reg == CW'(DEPTH))))
        else $error("ifu_fetch_queue: enqueue while full");
      assert (!(rsp_valid_i && (outstanding_reg == '0)))
        else $error("ifu_fetch_queue: response with no outstanding request");
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue (DEPTH=4).

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 64
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_issue_i, req_allow_o;
  logic        rsp_valid_i, rsp_pred_branch_i;
  logic [63:0] rsp_inst_i;
  logic [31:0] rsp_addr_i;
  logic        flush_flag_i, stall_i;
  logic [63:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        is_pred_branch_o, inst_valid_o;
  logic [2:0]  fq_count_o;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] NOP2 = {`INST_NOP, `INST_NOP};

  ifu_fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_issue_i(req_issue_i), .req_allow_o(req_allow_o),
    .rsp_valid_i(rsp_valid_i), .rsp_inst_i(rsp_inst_i), .rsp_addr_i(rsp_addr_i),
    .rsp_pred_branch_i(rsp_pred_branch_i),
    .flush_flag_i(flush_flag_i), .stall_i(stall_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .is_pred_branch_o(is_pred_branch_o), .inst_valid_o(inst_valid_o),
    .fq_count_o(fq_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] inst_of(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the whole head interface against an expected entry (or idle).
  task automatic chk_head(input string tag, input logic v, input logic [31:0] a);
    chk({tag, "_valid"}, 64'(inst_valid_o), 64'(v));
    if (v) begin
      chk({tag, "_addr"}, 64'(inst_addr_o), 64'(a));
      chk({tag, "_inst"}, inst_o, inst_of(a));
      chk({tag, "_pred"}, 64'(is_pred_branch_o), 64'(a[3]));
    end else begin
      chk({tag, "_addr"}, 64'(inst_addr_o), 64'(`ZeroWord));
      chk({tag, "_inst"}, inst_o, NOP2);
      chk({tag, "_pred"}, 64'(is_pred_branch_o), 64'd0);
    end
  endtask

  task automatic drive(input logic iss, input logic rv, input logic [31:0] a,
                       input logic fl, input logic st);
    req_issue_i       = iss;
    rsp_valid_i       = rv;
    rsp_addr_i        = rv ? a : 32'h0;
    rsp_inst_i        = rv ? inst_of(a) : 64'h0;
    rsp_pred_branch_i = rv & a[3];
    flush_flag_i      = fl;
    stall_i           = st;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  logic [31:0] exp_q[$];
  int          m_out, issued, delivered, resp_idx;
  logic        iss, rv, st, allow_exp;
  logic [31:0] ra;

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    // Reset state, observed before any clock edge.
    chk_head("rst", 1'b0, 32'h0);
    chk("rst_count", 64'(fq_count_o), 64'd0);
    chk("rst_allow", 64'(req_allow_o), 64'd1);
    nxt; nxt;
    rst = 1'b0;
    nxt; drive(0, 0, 0, 0, 0); settle;
    chk("idle_count", 64'(fq_count_o), 64'd0);
    chk_head("idle", 1'b0, 32'h0);

`ifdef IFU_FQ_BYPASS_EN
    // Bypass: an empty queue forwards the response in the same cycle.
    nxt; drive(1, 0, 0, 0, 0);
    nxt; drive(0, 1, 32'h100, 0, 0); settle;
    chk_head("byp_same", 1'b1, 32'h100);
    chk("byp_count0", 64'(fq_count_o), 64'd0);
    nxt; drive(0, 0, 0, 0, 0); settle;
    chk_head("byp_after", 1'b0, 32'h0);
    chk("byp_count1", 64'(fq_count_o), 64'd0);
    // Stalled bypass: the response is written to the queue.
    nxt; drive(1, 0, 0, 0, 0);
    nxt; drive(0, 1, 32'h108, 0, 1); settle;
    chk_head("byps_same", 1'b1, 32'h108);
    nxt; drive(0, 0, 0, 0, 0); settle;
    chk_head("byps_held", 1'b1, 32'h108);
    chk("byps_count", 64'(fq_count_o), 64'd1);
    nxt; settle;
    chk_head("byps_done", 1'b0, 32'h0);
`else
    // Four issues, four responses, one-cycle latency, credit exhaustion.
    for (int i = 0; i < 4; i++) begin
      nxt; drive(1, 0, 0, 0, 0); settle;
      chk("b_allow_pre", 64'(req_allow_o), 64'd1);
    end
    nxt; drive(0, 1, 32'h0, 0, 0); settle;
    chk("b_allow_full", 64'(req_allow_o), 64'd0);
    chk_head("b_lat", 1'b0, 32'h0);
    nxt; drive(0, 1, 32'h8, 0, 0); settle;
    chk_head("b_h0", 1'b1, 32'h0);
    chk("b_allow_h0", 64'(req_allow_o), 64'd0);
    nxt; drive(0, 1, 32'h10, 0, 0); settle;
    chk_head("b_h1", 1'b1, 32'h8);
    chk("b_allow_h1", 64'(req_allow_o), 64'd1);
    nxt; drive(0, 1, 32'h18, 0, 0); settle;
    chk_head("b_h2", 1'b1, 32'h10);
    nxt; drive(0, 0, 0, 0, 0); settle;
    chk_head("b_h3", 1'b1, 32'h18);
    chk("b_count_h3", 64'(fq_count_o), 64'd1);
    nxt; settle;
    chk_head("b_empty", 1'b0, 32'h0);
    chk("b_count_end", 64'(fq_count_o), 64'd0);

    // Fill to full under stall, then drain.
    for (int i = 0; i < 4; i++) begin
      nxt; drive(1, 0, 0, 0, 1);
    end
    for (int k = 0; k < 4; k++) begin
      nxt; drive(0, 1, 32'(8 * k), 0, 1); settle;
      if (k > 0) chk_head("c_hold", 1'b1, 32'h0);
    end
    nxt; drive(0, 0, 0, 0, 1); settle;
    chk("c_count_full", 64'(fq_count_o), 64'd4);
    chk("c_allow_full", 64'(req_allow_o), 64'd0);
    chk_head("c_head_full", 1'b1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      nxt; drive(0, 0, 0, 0, 0); settle;
      chk_head("c_drain", 1'b1, 32'(8 * k));
      chk("c_drain_count", 64'(fq_count_o), 64'(4 - k));
    end
    nxt; settle;
    chk_head("c_empty", 1'b0, 32'h0);
    chk("c_count_end", 64'(fq_count_o), 64'd0);

    // Flush with two outstanding and one response in the flush cycle.
    nxt; drive(1, 0, 0, 0, 0);
    nxt; drive(1, 0, 0, 0, 0);
    nxt; drive(0, 1, 32'h20, 1, 0); settle;
    chk_head("d_flush", 1'b0, 32'h0);
    nxt; drive(1, 1, 32'h40, 0, 0); settle;
    chk_head("d_stale_in", 1'b0, 32'h0);
    nxt; drive(0, 0, 0, 0, 0); settle;
    chk_head("d_dropped", 1'b0, 32'h0);
    chk("d_count_drop", 64'(fq_count_o), 64'd0);
    nxt; drive(0, 1, 32'h80, 0, 0); settle;
    chk_head("d_live_in", 1'b0, 32'h0);
    nxt; drive(0, 0, 0, 0, 0); settle;
    chk_head("d_live_out", 1'b1, 32'h80);
    nxt; settle;
    chk_head("d_empty", 1'b0, 32'h0);

    // Flush masks a non-empty head immediately and empties the queue.
    nxt; drive(1, 0, 0, 0, 1);
    nxt; drive(0, 1, 32'h60, 0, 1);
    nxt; drive(0, 0, 0, 1, 1); settle;
    chk("e_count_pre", 64'(fq_count_o), 64'd1);
    chk_head("e_masked", 1'b0, 32'h0);
    nxt; drive(0, 0, 0, 0, 0); settle;
    chk("e_count_post", 64'(fq_count_o), 64'd0);
    chk("e_allow_post", 64'(req_allow_o), 64'd1);

    // Pointer wrap with random stall against a scoreboard.
    m_out = 0; issued = 0; delivered = 0; resp_idx = 0;
    for (int cyc = 0; cyc < 300 && delivered < 10; cyc++) begin
      nxt;
      st  = 1'($urandom_range(0, 1));
      rv  = (m_out > 0) && (1'($urandom_range(0, 1)) == 1'b1);
      allow_exp = (exp_q.size() + m_out) < 4;
      iss = allow_exp && (issued < 10);
      ra  = 32'h200 + 32'(8 * resp_idx);
      drive(iss, rv, ra, 0, st); settle;
      chk("f_count", 64'(fq_count_o), 64'(exp_q.size()));
      chk("f_allow", 64'(req_allow_o), 64'(allow_exp));
      if (exp_q.size() > 0) chk_head("f_head", 1'b1, exp_q[0]);
      else                  chk_head("f_head", 1'b0, 32'h0);
      if (exp_q.size() > 0 && !st) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (rv) begin
        exp_q.push_back(ra);
        resp_idx++;
      end
      m_out = m_out + int'(iss) - int'(rv);
      if (iss) issued++;
    end
    chk("f_delivered", 64'(delivered), 64'd10);
    nxt; drive(0, 0, 0, 0, 0); settle;
    chk("f_count_end", 64'(fq_count_o), 64'd0);

    // Asynchronous reset mid-burst with three entries buffered.
    for (int i = 0; i < 3; i++) begin
      nxt; drive(1, 0, 0, 0, 1);
    end
    for (int k = 0; k < 3; k++) begin
      nxt; drive(0, 1, 32'h300 + 32'(8 * k), 0, 1);
    end
    nxt; drive(0, 0, 0, 0, 1); settle;
    chk("g_count_pre", 64'(fq_count_o), 64'd3);
    chk_head("g_head_pre", 1'b1, 32'h300);
    rst = 1'b1;
    #1;
    chk_head("g_rst", 1'b0, 32'h0);
    chk("g_rst_count", 64'(fq_count_o), 64'd0);
    chk("g_rst_allow", 64'(req_allow_o), 64'd1);
    nxt; rst = 1'b0; drive(0, 0, 0, 0, 0); settle;
    chk("g_count_rel", 64'(fq_count_o), 64'd0);
    nxt; drive(1, 0, 0, 0, 0);
    nxt; drive(0, 1, 32'h340, 0, 0); settle;
    chk_head("g_live_in", 1'b0, 32'h0);
    nxt; drive(0, 0, 0, 0, 0); settle;
    chk_head("g_live_out", 1'b1, 32'h340);
    nxt; settle;
    chk_head("g_empty", 1'b0, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
